// File: rtl/color_toggle_game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | color_game_pkg : shared state encoding and default board constants |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package color_game_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_CHECK = 2'd2,
      ST_WIN   = 2'd3
   } state_t;

   localparam logic [2:0]  DEF_COLOR_TARGET = 3'b010;
   localparam logic [23:0] DEF_INIT_COLORS  =
      {3'b111, 3'b011, 3'b110, 3'b011, 3'b110, 3'b001, 3'b001, 3'b111};

endpackage
`default_nettype wire

// File: rtl/color_toggle_game_sw_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sw_conditioner : synchroniser, optional debounce, rising-edge press |
// | Debounce enabled by COLOR_GAME_DEBOUNCE_EN.  Rev 1.0               |
// +--------------------------------------------------------------------+
module sw_conditioner #(
   parameter int DB_CNT = 250_000
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic press
);

   logic sync1, sync2, level, level_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
      end
   end

`ifdef COLOR_GAME_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CNT + 1);
   logic [CW-1:0] db_cnt;

   // Level only moves after DB_CNT consecutive cycles of disagreement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level  <= 1'b0;
         db_cnt <= '0;
      end else if (sync2 == level) begin
         db_cnt <= '0;
      end else if (db_cnt == CW'(DB_CNT)) begin
         level  <= sync2;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) level <= 1'b0;
      else     level <= sync2;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_d <= 1'b0;
      else     level_d <= level;
   end

   assign press = level & ~level_d;

   generate
      if (DB_CNT < 1) begin : g_bad_db_cnt
         $error("sw_conditioner: DB_CNT must be at least 1");
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/color_toggle_game.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | color_toggle_game : N-square lights-out puzzle with win blink      |
// | Optional switch debounce via COLOR_GAME_DEBOUNCE_EN.  Rev 1.0      |
// +--------------------------------------------------------------------+
module color_toggle_game
   import color_game_pkg::*;
#(
   parameter int              N            = 8,
   parameter int              DW           = 3,
   parameter logic [N*DW-1:0] INIT_COLORS  = DEF_INIT_COLORS,
   parameter logic [DW-1:0]   COLOR_TARGET = DEF_COLOR_TARGET,
   parameter int              MOVES_W      = 8,
   parameter int              BLINK_CNT    = 25_000_000,
   parameter int              DB_CNT       = 250_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        sw,
   input  logic                new_game,
   output logic [N*DW-1:0]     colors,
   output logic [MOVES_W-1:0]  moves,
   output logic                won
);

   localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

   state_t               state, state_nxt;
   logic [N-1:0]         press, first_press, flip;
   logic [N*DW-1:0]      board, board_nxt;
   logic [MOVES_W-1:0]   moves_nxt;
   logic                 won_nxt, all_target, blank, blank_nxt;
   logic [BW-1:0]        blink_cnt, blink_cnt_nxt;

   generate
      for (genvar i = 0; i < N; i++) begin : g_sw
         sw_conditioner #(.DB_CNT(DB_CNT)) u_cond (
            .clk   (clk),
            .rst   (rst),
            .sw    (sw[i]),
            .press (press[i])
         );
      end
      if (N < 3) begin : g_bad_n
         $error("color_toggle_game: N must be at least 3");
      end
   endgenerate

   // Lowest pressed switch wins; flip it and its two ring neighbours.
   always_comb begin
      first_press = press & (~press + N'(1));
      flip        = first_press
                  | {first_press[N-2:0], first_press[N-1]}
                  | {first_press[0], first_press[N-1:1]};
      all_target  = 1'b1;
      for (int j = 0; j < N; j++) begin
         if (board[j*DW +: DW] != COLOR_TARGET) all_target = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD:  state_nxt = ST_PLAY;
         ST_PLAY:  if (|press) state_nxt = ST_CHECK;
         ST_CHECK: state_nxt = all_target ? ST_WIN : ST_PLAY;
         ST_WIN:   state_nxt = ST_WIN;
         default:  state_nxt = ST_LOAD;
      endcase
      if (new_game) state_nxt = ST_LOAD;
   end

   always_comb begin
      board_nxt     = board;
      moves_nxt     = moves;
      won_nxt       = won;
      blink_cnt_nxt = '0;
      blank_nxt     = 1'b0;
      case (state)
         ST_LOAD: begin
            board_nxt = INIT_COLORS;
            moves_nxt = '0;
            won_nxt   = 1'b0;
         end
         ST_PLAY: begin
            if (!new_game && (|press)) begin
               for (int j = 0; j < N; j++) begin
                  if (flip[j]) board_nxt[j*DW +: DW] = ~board[j*DW +: DW];
               end
               if (moves != {MOVES_W{1'b1}}) moves_nxt = moves + 1'b1;
            end
         end
         ST_CHECK: if (all_target) won_nxt = 1'b1;
         default: ;
      endcase
      if (new_game) won_nxt = 1'b0;
      // Blink phase restarts on every entry to WIN, starting with the board shown.
      if (state == ST_WIN && state_nxt == ST_WIN) begin
         if (blink_cnt == BW'(BLINK_CNT - 1)) begin
            blank_nxt = ~blank;
         end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
            blank_nxt     = blank;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         board     <= INIT_COLORS;
         colors    <= INIT_COLORS;
         moves     <= '0;
         won       <= 1'b0;
         blink_cnt <= '0;
         blank     <= 1'b0;
      end else begin
         board     <= board_nxt;
         colors    <= blank_nxt ? '0 : board_nxt;
         moves     <= moves_nxt;
         won       <= won_nxt;
         blink_cnt <= blink_cnt_nxt;
         blank     <= blank_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_color_toggle_game.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_color_toggle_game : directed checks on an 8-square and a 3-square|
// | board.  Rev 1.0                                                    |
// +--------------------------------------------------------------------+
module tb_color_toggle_game;
   import color_game_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  sw;
   logic        new_game;
   logic [23:0] colors;
   logic [7:0]  moves;
   logic        won;

   logic [2:0]  sw3;
   logic        new_game3;
   logic [8:0]  colors3;
   logic [7:0]  moves3;
   logic        won3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   color_toggle_game dut (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw),
      .new_game (new_game),
      .colors   (colors),
      .moves    (moves),
      .won      (won)
   );

   color_toggle_game #(
      .N           (3),
      .DW          (3),
      .INIT_COLORS (9'h16D),
      .BLINK_CNT   (4)
   ) dut3 (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw3),
      .new_game (new_game3),
      .colors   (colors3),
      .moves    (moves3),
      .won      (won3)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; sw = '0; new_game = 1'b0; sw3 = '0; new_game3 = 1'b0;
      tick(3);
      check("reset_colors", 64'(colors), 64'h EF3C4F);
      check("reset_moves", 64'(moves), 64'd0);
      check("reset_won", 64'(won), 64'd0);
      check("reset_colors3", 64'(colors3), 64'h16D);
      rst = 1'b0;
      tick(1);
      check("load_to_play", 64'(dut.state), 64'(ST_PLAY));
      tick(2);

      // Square 1 starts at 3'b001, so it inverts to 3'b110.
      sw[0] = 1'b1;
      tick(3);
      check("sw0_latency", 64'(colors), 64'h EF3C4F);
      tick(1);
      check("sw0_colors", 64'(colors), 64'h 0F3C70);
      check("sw0_moves", 64'(moves), 64'd1);
      sw[0] = 1'b0;
      tick(6);
      check("fall_ignored_colors", 64'(colors), 64'h 0F3C70);
      check("fall_ignored_moves", 64'(moves), 64'd1);

      new_game = 1'b1; tick(1); new_game = 1'b0; tick(1);
      check("restart_colors", 64'(colors), 64'h EF3C4F);
      check("restart_moves", 64'(moves), 64'd0);
      tick(2);

      sw[3] = 1'b1; sw[5] = 1'b1;
      tick(4);
      check("multi_colors", 64'(colors), 64'h EF438F);
      check("multi_moves", 64'(moves), 64'd1);
      sw = '0;
      tick(4);
      sw[5] = 1'b1;
      tick(4);
      check("sw5_colors", 64'(colors), 64'h F0B38F);
      check("sw5_moves", 64'(moves), 64'd2);
      sw[5] = 1'b0;
      tick(4);

      // new_game lands in the same cycle as the sw[1] press pulse.
      sw[1] = 1'b1;
      tick(3);
      new_game = 1'b1; tick(1); new_game = 1'b0;
      check("prio_press_dropped", 64'(colors), 64'h F0B38F);
      check("prio_moves_held", 64'(moves), 64'd2);
      tick(1);
      check("prio_load_colors", 64'(colors), 64'h EF3C4F);
      check("prio_load_moves", 64'(moves), 64'd0);
      tick(4);
      check("prio_stale_colors", 64'(colors), 64'h EF3C4F);
      check("prio_stale_moves", 64'(moves), 64'd0);
      sw[1] = 1'b0;
      tick(4);

      for (int i = 0; i < 300; i++) begin
         sw[0] = 1'b1; tick(4);
         sw[0] = 1'b0; tick(4);
         if (i == 253) check("moves_254", 64'(moves), 64'd254);
      end
      check("moves_saturated", 64'(moves), 64'd255);
      check("even_presses_colors", 64'(colors), 64'h EF3C4F);
      check("no_win_8", 64'(won), 64'd0);

      sw3[1] = 1'b1;
      tick(3);
      check("n3_latency", 64'(colors3), 64'h16D);
      tick(1);
      check("n3_colors", 64'(colors3), 64'h092);
      check("n3_moves", 64'(moves3), 64'd1);
      check("n3_won_in_check", 64'(won3), 64'd0);
      tick(1);
      check("n3_won", 64'(won3), 64'd1);
      check("n3_blink_on0", 64'(colors3), 64'h092);
      tick(3);
      check("n3_blink_on3", 64'(colors3), 64'h092);
      tick(1);
      check("n3_blink_off", 64'(colors3), 64'h000);
      tick(4);
      check("n3_blink_on_again", 64'(colors3), 64'h092);

      sw3[1] = 1'b0; tick(2);
      sw3[0] = 1'b1; tick(6);
      check("n3_win_press_moves", 64'(moves3), 64'd1);
      check("n3_win_press_won", 64'(won3), 64'd1);
      sw3[0] = 1'b0; tick(2);

      new_game3 = 1'b1; tick(1); new_game3 = 1'b0;
      check("n3_newgame_won", 64'(won3), 64'd0);
      tick(1);
      check("n3_newgame_colors", 64'(colors3), 64'h16D);
      check("n3_newgame_moves", 64'(moves3), 64'd0);
      check("n3_newgame_state", 64'(dut3.state), 64'(ST_PLAY));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
